// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: load kinds and architectural constants.
package mips_pkg;

    typedef enum logic [2:0] {
        LOAD_WORD  = 3'b000,
        LOAD_BYTE  = 3'b001,
        LOAD_HALF  = 3'b010,
        LOAD_BYTEU = 3'b011,
        LOAD_HALFU = 3'b100
    } load_type_e;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/mem_wb_stage_load_extender.sv
// Sign/zero extension of sub-word load data; unknown load codes pass the word through.
module load_extender
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [2:0]            load_type,
    output logic [DATA_WIDTH-1:0] ext_data
);

    always_comb begin
        ext_data = data;
        case (load_type)
            LOAD_BYTE:  ext_data = {{(DATA_WIDTH-8){data[7]}}, data[7:0]};
            LOAD_HALF:  ext_data = {{(DATA_WIDTH-16){data[15]}}, data[15:0]};
            LOAD_BYTEU: ext_data = {{(DATA_WIDTH-8){1'b0}}, data[7:0]};
            LOAD_HALFU: ext_data = {{(DATA_WIDTH-16){1'b0}}, data[15:0]};
            default:    ext_data = data;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback select, retired-instruction counter and
// sticky halt flag.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic                      i_valid,
    input  logic                      i_reg_write,
    input  logic                      i_mem_to_reg,
    input  logic                      i_link,
    input  logic                      i_halt,
    input  logic [2:0]                i_load_type,
    input  logic [DATA_WIDTH-1:0]     i_mem_data,
    input  logic [DATA_WIDTH-1:0]     i_alu_result,
    input  logic [DATA_WIDTH-1:0]     i_link_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd,
    output logic                      o_wb_en,
    output logic [REG_ADDR_WIDTH-1:0] o_wb_rd,
    output logic [DATA_WIDTH-1:0]     o_wb_data,
    output logic                      o_valid,
    output logic                      o_halted,
    output logic [CNT_WIDTH-1:0]      o_retired
);

    logic                      valid_q, valid_d;
    logic                      reg_write_q, reg_write_d;
    logic                      mem_to_reg_q, mem_to_reg_d;
    logic                      link_q, link_d;
    logic [2:0]                load_type_q, load_type_d;
    logic [DATA_WIDTH-1:0]     mem_data_q, mem_data_d;
    logic [DATA_WIDTH-1:0]     alu_result_q, alu_result_d;
    logic [DATA_WIDTH-1:0]     link_addr_q, link_addr_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      halted_q, halted_d;
    logic [CNT_WIDTH-1:0]      retired_q, retired_d;
    logic                      ld;
    logic [DATA_WIDTH-1:0]     ext_data;

    assign ld = !i_stall && !i_flush && !halted_q;

    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        link_d       = link_q;
        load_type_d  = load_type_q;
        mem_data_d   = mem_data_q;
        alu_result_d = alu_result_q;
        link_addr_d  = link_addr_q;
        rd_d         = rd_q;
        halted_d     = halted_q;
        retired_d    = retired_q;
        if (rst) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            link_d       = 1'b0;
            load_type_d  = 3'b000;
            mem_data_d   = '0;
            alu_result_d = '0;
            link_addr_d  = '0;
            rd_d         = '0;
            halted_d     = 1'b0;
            retired_d    = '0;
        end else if (i_flush || (halted_q && !i_stall)) begin
            // Once halted, every would-be capture becomes a bubble.
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (ld) begin
            valid_d      = i_valid;
            reg_write_d  = i_reg_write;
            mem_to_reg_d = i_mem_to_reg;
            link_d       = i_link;
            load_type_d  = i_load_type;
            mem_data_d   = i_mem_data;
            alu_result_d = i_alu_result;
            link_addr_d  = i_link_addr;
            rd_d         = i_rd;
            if (i_valid) begin
                retired_d = retired_q + CNT_WIDTH'(1);
                if (i_halt) halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        valid_q      <= valid_d;
        reg_write_q  <= reg_write_d;
        mem_to_reg_q <= mem_to_reg_d;
        link_q       <= link_d;
        load_type_q  <= load_type_d;
        mem_data_q   <= mem_data_d;
        alu_result_q <= alu_result_d;
        link_addr_q  <= link_addr_d;
        rd_q         <= rd_d;
        halted_q     <= halted_d;
        retired_q    <= retired_d;
    end

    load_extender #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_extender (
        .data     (mem_data_q),
        .load_type(load_type_q),
        .ext_data (ext_data)
    );

    always_comb begin
        if (link_q) begin
            o_wb_data = link_addr_q;
        end else if (mem_to_reg_q) begin
            o_wb_data = ext_data;
        end else begin
            o_wb_data = alu_result_q;
        end
    end

    assign o_wb_en   = valid_q && reg_write_q && (rd_q != REG_ADDR_WIDTH'(REG_ZERO));
    assign o_wb_rd   = rd_q;
    assign o_valid   = valid_q;
    assign o_halted  = halted_q;
    assign o_retired = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage, with a narrow-counter instance for wrap.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stall, i_flush, i_valid, i_reg_write, i_mem_to_reg, i_link, i_halt;
    logic [2:0]  i_load_type;
    logic [31:0] i_mem_data, i_alu_result, i_link_addr;
    logic [4:0]  i_rd;
    logic        o_wb_en, o_valid, o_halted;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data, o_retired;
    logic        n_wb_en, n_valid, n_halted;
    logic [4:0]  n_wb_rd;
    logic [31:0] n_wb_data;
    logic [3:0]  n_retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
        .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg), .i_link(i_link),
        .i_halt(i_halt), .i_load_type(i_load_type), .i_mem_data(i_mem_data),
        .i_alu_result(i_alu_result), .i_link_addr(i_link_addr), .i_rd(i_rd),
        .o_wb_en(o_wb_en), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_valid(o_valid),
        .o_halted(o_halted), .o_retired(o_retired)
    );

    mem_wb_stage #(.CNT_WIDTH(4)) dut_narrow (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
        .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg), .i_link(i_link),
        .i_halt(i_halt), .i_load_type(i_load_type), .i_mem_data(i_mem_data),
        .i_alu_result(i_alu_result), .i_link_addr(i_link_addr), .i_rd(i_rd),
        .o_wb_en(n_wb_en), .o_wb_rd(n_wb_rd), .o_wb_data(n_wb_data), .o_valid(n_valid),
        .o_halted(n_halted), .o_retired(n_retired)
    );

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic lnk,
                         input logic hlt, input logic [2:0] lt, input logic [31:0] md,
                         input logic [31:0] alu, input logic [31:0] la, input logic [4:0] rd);
        i_valid = v; i_reg_write = rw; i_mem_to_reg = m2r; i_link = lnk; i_halt = hlt;
        i_load_type = lt; i_mem_data = md; i_alu_result = alu; i_link_addr = la; i_rd = rd;
    endtask

    task automatic do_reset();
        rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0);
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h55, 32'hDEAD, 32'h80, 5'd5);
        cycle();
        cycle();
        checks++;
        if ({o_valid, o_wb_en, o_halted} !== 3'b000) begin
            $display("FAIL reset_flags: got %b exp 000", {o_valid, o_wb_en, o_halted});
            errors++;
        end
        checks++;
        if (o_wb_rd !== 5'd0 || o_wb_data !== 32'h0) begin
            $display("FAIL reset_wb: got rd=%0d data=%h exp 0/0", o_wb_rd, o_wb_data);
            errors++;
        end
        checks++;
        if (o_retired !== 32'd0) begin
            $display("FAIL reset_retired: got %0d exp 0", o_retired);
            errors++;
        end
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'hDEAD, 32'h0, 5'd5);
        cycle();
        checks++;
        if (o_retired !== 32'd1 || o_wb_data !== 32'hDEAD || o_wb_en !== 1'b1) begin
            $display("FAIL first_after_reset: got ret=%0d data=%h en=%b exp 1/0000dead/1",
                     o_retired, o_wb_data, o_wb_en);
            errors++;
        end
    endtask

    task automatic test_subword();
        logic [2:0]  lt  [6] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b000, 3'b111};
        logic [31:0] md  [6] = '{32'h000000F0, 32'h000000F0, 32'h00008001, 32'h00008001,
                                 32'h8001F0F0, 32'hA5A5807F};
        logic [31:0] exp [6] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8001, 32'h00008001,
                                 32'h8001F0F0, 32'hA5A5807F};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, lt[i], md[i], 32'h1111, 32'h0, 5'd8);
            cycle();
            checks++;
            if (o_wb_data !== exp[i]) begin
                $display("FAIL load_ext[%0d]: got %h exp %h", i, o_wb_data, exp[i]);
                errors++;
            end
            checks++;
            if (o_wb_en !== 1'b1 || o_wb_rd !== 5'd8) begin
                $display("FAIL load_wb[%0d]: got en=%b rd=%0d exp 1/8", i, o_wb_en, o_wb_rd);
                errors++;
            end
        end
    endtask

    task automatic test_wb_select();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'hFFFF, 32'h1234, 32'h40, 5'd0);
        cycle();
        checks++;
        if (o_wb_en !== 1'b0 || o_valid !== 1'b1 || o_wb_data !== 32'h1234) begin
            $display("FAIL reg_zero: got en=%b valid=%b data=%h exp 0/1/00001234",
                     o_wb_en, o_valid, o_wb_data);
            errors++;
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 32'hFF, 32'h1234, 32'h40, 5'd31);
        cycle();
        checks++;
        if (o_wb_data !== 32'h40 || o_wb_en !== 1'b1 || o_wb_rd !== 5'd31) begin
            $display("FAIL link_select: got data=%h en=%b rd=%0d exp 00000040/1/31",
                     o_wb_data, o_wb_en, o_wb_rd);
            errors++;
        end
        checks++;
        if (o_retired !== 32'd2) begin
            $display("FAIL wb_retired: got %0d exp 2", o_retired);
            errors++;
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'hAAAA, 32'h0, 5'd3);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'hBBBB, 32'h0, 5'd4);
        i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (o_wb_data !== 32'hAAAA || o_wb_rd !== 5'd3 || o_wb_en !== 1'b1 ||
                o_retired !== 32'd1) begin
                $display("FAIL stall_hold[%0d]: got data=%h rd=%0d en=%b ret=%0d exp aaaa/3/1/1",
                         i, o_wb_data, o_wb_rd, o_wb_en, o_retired);
                errors++;
            end
        end
        i_flush = 1'b1;
        cycle();
        checks++;
        if (o_valid !== 1'b0 || o_wb_en !== 1'b0 || o_retired !== 32'd1) begin
            $display("FAIL stall_flush: got valid=%b en=%b ret=%0d exp 0/0/1",
                     o_valid, o_wb_en, o_retired);
            errors++;
        end
        i_stall = 1'b0; i_flush = 1'b0;
        cycle();
        checks++;
        if (o_wb_data !== 32'hBBBB || o_retired !== 32'd2) begin
            $display("FAIL after_release: got data=%h ret=%0d exp bbbb/2", o_wb_data, o_retired);
            errors++;
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'(i), 32'h0, 5'd2);
            cycle();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0);
        cycle();
        checks++;
        if (o_halted !== 1'b1 || o_retired !== 32'd6) begin
            $display("FAIL halt_set: got halted=%b ret=%0d exp 1/6", o_halted, o_retired);
            errors++;
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h77, 32'h0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (o_retired !== 32'd6 || o_valid !== 1'b0 || o_wb_en !== 1'b0 ||
                o_halted !== 1'b1) begin
                $display("FAIL halt_ignore[%0d]: got ret=%0d valid=%b en=%b halted=%b exp 6/0/0/1",
                         i, o_retired, o_valid, o_wb_en, o_halted);
                errors++;
            end
        end
        do_reset();
        checks++;
        if (o_halted !== 1'b0 || o_retired !== 32'd0) begin
            $display("FAIL halt_clear: got halted=%b ret=%0d exp 0/0", o_halted, o_retired);
            errors++;
        end
    endtask

    task automatic test_halt_stall();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0);
        i_stall = 1'b1;
        cycle();
        cycle();
        checks++;
        if (o_halted !== 1'b0 || o_retired !== 32'd0) begin
            $display("FAIL halt_stalled: got halted=%b ret=%0d exp 0/0", o_halted, o_retired);
            errors++;
        end
        i_stall = 1'b0;
        cycle();
        checks++;
        if (o_halted !== 1'b1 || o_retired !== 32'd1) begin
            $display("FAIL halt_released: got halted=%b ret=%0d exp 1/1", o_halted, o_retired);
            errors++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h5, 32'h0, 5'd1);
        for (int i = 0; i < 17; i++) cycle();
        checks++;
        if (n_retired !== 4'd1) begin
            $display("FAIL wrap_narrow: got %0d exp 1", n_retired);
            errors++;
        end
        checks++;
        if (o_retired !== 32'd17) begin
            $display("FAIL wrap_wide: got %0d exp 17", o_retired);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_subword();
        test_wb_select();
        test_stall_flush();
        test_halt();
        test_halt_stall();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback unit, directly downstream of the data memory stage.
- Captures the memory read data, ALU result, link address and control at posedge clk.
- Applies sign or zero extension for sub-word loads and selects the writeback value for the register file.
- Provides a retired-instruction counter and a sticky halt flag for the debug unit.

Parameters:
- DATA_WIDTH, 32, datapath width.
- REG_ADDR_WIDTH, 5, register-file index width.
- CNT_WIDTH, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- i_stall  in  1  hold the stage contents.
- i_flush  in  1  load a bubble.
- i_valid  in  1  the MEM-stage instruction is real.
- i_reg_write  in  1  the instruction writes the register file.
- i_mem_to_reg  in  1  select memory data for writeback.
- i_link  in  1  select the link address for writeback (JAL/JALR); has priority over i_mem_to_reg.
- i_halt  in  1  the instruction is HALT.
- i_load_type  in  3  load kind, encoded per mips_pkg.
- i_mem_data  in  DATA_WIDTH  data memory read_data, already byte-masked and zero-filled.
- i_alu_result  in  DATA_WIDTH  ALU result.
- i_link_addr  in  DATA_WIDTH  PC+8.
- i_rd  in  REG_ADDR_WIDTH  destination register.
- o_wb_en  out  1  register-file write enable.
- o_wb_rd  out  REG_ADDR_WIDTH  write address.
- o_wb_data  out  DATA_WIDTH  write data; also the forwarding source.
- o_valid  out  1  the stage holds a real instruction.
- o_halted  out  1  sticky halt flag.
- o_retired  out  CNT_WIDTH  count of instructions retired.

Behaviour:
- Reset (rst=1 at posedge):
  - All stage registers clear; o_valid=0, o_wb_en=0, o_wb_rd=0, o_wb_data=0, o_halted=0, o_retired=0.
  - Reset overrides stall, flush and halt.
- Load condition `ld` = !rst & !i_stall & !i_flush & !o_halted.
  - On `ld`: capture all inputs, and set valid_q=i_valid.
  - Latency is one cycle: the outputs reflect the instruction present at the inputs on the previous edge.
- Flush (i_flush=1, no rst): load a bubble, i.e. valid_q=0 and reg_write_q=0. Flush wins over a simultaneous stall.
- Stall (i_stall=1, no flush, no rst): all registers hold. Outputs are unchanged, and o_wb_en stays asserted if it was asserted, so a rewrite of the same value is harmless.
- Halt:
  - When `ld` captures i_valid=1 and i_halt=1, o_halted is set on the same edge.
  - While o_halted=1, further captures are replaced by bubbles; only rst clears o_halted.
- o_wb_en = valid_q & reg_write_q & (rd_q != 0). Writes to $0 are always suppressed.
- Writeback select: i_link → link_addr_q; else i_mem_to_reg → ext(mem_data_q, load_type_q); else alu_result_q.
- Extension (combinational on registered data), uses bits [15:0]/[7:0] only:
  - WORD: pass through.
  - BYTE: sign-extend bit 7.
  - HALF: sign-extend bit 15.
  - BYTEU: zero-extend [7:0].
  - HALFU: zero-extend [15:0].
  - Undefined codes are treated as WORD.
- Retired counter:
  - Increments by 1 on every edge where `ld` and i_valid are both 1, including the HALT instruction itself.
  - Bubbles, stalls and flushes do not count.
  - Wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Halt and stall arriving together: the stall holds, so HALT is not captured until the stall releases.

Decomposition:
- Package mips_pkg holds:
  - LOAD_WORD=3'b000, LOAD_BYTE=3'b001, LOAD_HALF=3'b010, LOAD_BYTEU=3'b011, LOAD_HALFU=3'b100.
  - REG_ZERO=0.
- One combinational sub-module, load_extender (inputs: data, load_type; output: extended data), instantiated once on the registered data.
- The pipeline register, counter and halt logic stay in mem_wb_stage.

Test Plan:
- Reset: rst held 2 cycles with i_valid=1 applied → all outputs 0; first valid instruction after release sets o_retired=1.
- Sub-word loads: i_mem_data=0x000000F0, i_mem_to_reg=1, i_reg_write=1, rd=8 →
  - BYTE gives o_wb_data=0xFFFFFFF0; BYTEU gives 0x000000F0.
  - i_mem_data=0x00008001: HALF gives 0xFFFF8001; HALFU gives 0x00008001.
  - o_wb_en=1, o_wb_rd=8 one cycle after capture.
- Writeback select and $0: i_alu_result=0x1234, rd=0, reg_write=1 → o_wb_en=0. Then i_link=1, i_link_addr=0x40, rd=31 → o_wb_data=0x40, o_wb_en=1.
- Stall and flush: stall 3 cycles → outputs and o_retired frozen. Stall+flush in the same cycle → o_valid=0, o_wb_en=0, counter unchanged.
- Halt: 5 valid instructions then HALT → o_halted=1, o_retired=6. Further valid inputs are ignored and the counter stays 6 until rst.
- Counter wrap: preload via a CNT_WIDTH=4 instance and feed 17 valid instructions → o_retired=1.
